// File: rtl/pixel_source_selector.sv
// pixel_source_selector: drains N FWFT pixel FIFOs, tracks per-source frame lock, and routes locked sources to bg/fg
module pixel_source_selector #(
  parameter int NUM_SOURCES    = 2,
  parameter int SEL_WIDTH      = 1,
  parameter int PRECISION      = 11,
  parameter int PIXEL_SIZE     = 16,
  parameter int WORD_W         = 2*PRECISION+PIXEL_SIZE,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13,
  parameter int DEFAULT_BG     = 1,
  parameter int DEFAULT_FG     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SOURCES*WORD_W-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]        src_empty,
  output logic [NUM_SOURCES-1:0]        src_read,
  input  logic [SEL_WIDTH-1:0]          bg_select,
  input  logic [SEL_WIDTH-1:0]          fg_select,
  output logic [PRECISION-1:0]          bg_x,
  output logic [PRECISION-1:0]          bg_y,
  output logic [PIXEL_SIZE-1:0]         bg_data,
  output logic                          bg_valid,
  output logic [PRECISION-1:0]          fg_x,
  output logic [PRECISION-1:0]          fg_y,
  output logic [PIXEL_SIZE-1:0]         fg_data,
  output logic                          fg_valid,
  input  logic                          fg_ready,
  output logic [NUM_SOURCES-1:0]        src_locked,
  output logic [SEL_WIDTH-1:0]          active_bg,
  output logic [SEL_WIDTH-1:0]          active_fg
);
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  localparam logic [TIMEOUT_WIDTH-1:0] TMO = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [SEL_WIDTH:0] NS = (SEL_WIDTH+1)'(NUM_SOURCES);
  lock_t state_q [NUM_SOURCES];
  lock_t state_n [NUM_SOURCES];
  logic [TIMEOUT_WIDTH-1:0] cnt_q [NUM_SOURCES];
  logic [TIMEOUT_WIDTH-1:0] cnt_n [NUM_SOURCES];
  logic [SEL_WIDTH-1:0] pend_bg_q, pend_fg_q, pend_bg, pend_fg, bg_src, fg_src;
  logic [NUM_SOURCES-1:0] origin, fg_cand, pop, fwd;
  logic fg_room, bg_sw, fg_sw, bg_fwd, fg_load;
  logic [WORD_W-1:0] bg_word, fg_word;
  assign src_read = pop;
  always_comb begin
    pend_bg = {1'b0, bg_select} < NS ? bg_select : pend_bg_q;
    pend_fg = {1'b0, fg_select} < NS ? fg_select : pend_fg_q;
    fg_room = !fg_valid || fg_ready;
    bg_sw = 1'b0;
    fg_sw = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      origin[i] = src_data[i*WORD_W+PIXEL_SIZE +: 2*PRECISION] == '0;
      // a pending fg source's frame-start word must wait for fg room, or it would be lost
      fg_cand[i] = active_fg == SEL_WIDTH'(i) || (pend_fg == SEL_WIDTH'(i) && origin[i]);
      pop[i] = !rst && !src_empty[i] && (!fg_cand[i] || fg_room);
      fwd[i] = pop[i] && (state_q[i] == LOCKED || origin[i]);
      if (pend_bg == SEL_WIDTH'(i) && pend_bg != active_bg && pop[i] && origin[i]) bg_sw = 1'b1;
      if (pend_fg == SEL_WIDTH'(i) && pend_fg != active_fg && pop[i] && origin[i]) fg_sw = 1'b1;
      cnt_n[i] = pop[i] ? '0 : cnt_q[i] == TMO ? cnt_q[i] : cnt_q[i] + TIMEOUT_WIDTH'(1);
      state_n[i] = pop[i] && origin[i] ? LOCKED : cnt_n[i] == TMO ? UNLOCKED : state_q[i];
      src_locked[i] = state_q[i] == LOCKED;
    end
    bg_src = bg_sw ? pend_bg : active_bg;
    fg_src = fg_sw ? pend_fg : active_fg;
    bg_fwd = 1'b0;
    fg_load = 1'b0;
    bg_word = '0;
    fg_word = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (bg_src == SEL_WIDTH'(i) && fwd[i]) begin
        bg_fwd = 1'b1;
        bg_word = src_data[i*WORD_W +: WORD_W];
      end
      if (fg_src == SEL_WIDTH'(i) && fwd[i]) begin
        fg_load = 1'b1;
        fg_word = src_data[i*WORD_W +: WORD_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        state_q[i] <= UNLOCKED;
        cnt_q[i] <= '0;
      end
      pend_bg_q <= SEL_WIDTH'(DEFAULT_BG);
      pend_fg_q <= SEL_WIDTH'(DEFAULT_FG);
      active_bg <= SEL_WIDTH'(DEFAULT_BG);
      active_fg <= SEL_WIDTH'(DEFAULT_FG);
      bg_valid <= 1'b0;
      fg_valid <= 1'b0;
      {bg_x, bg_y, bg_data} <= '0;
      {fg_x, fg_y, fg_data} <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        state_q[i] <= state_n[i];
        cnt_q[i] <= cnt_n[i];
      end
      pend_bg_q <= pend_bg;
      pend_fg_q <= pend_fg;
      if (bg_sw) active_bg <= pend_bg;
      if (fg_sw) active_fg <= pend_fg;
      bg_valid <= bg_fwd;
      if (bg_fwd) {bg_x, bg_y, bg_data} <= bg_word;
      if (fg_load) begin
        fg_valid <= 1'b1;
        {fg_x, fg_y, fg_data} <= fg_word;
      end else if (fg_ready) begin
        fg_valid <= 1'b0;
      end
    end
  end
endmodule
